speed_level_ticker: RTL and testbench

- Downstream consumer of the speed-control FSM's ENABLE / UP_DOWN step commands.
- Holds a saturating speed level 0..MAX_LEVEL.
- Generates a one-cycle TICK strobe whose period shrinks as the level rises. Level 0 means stopped, with no ticks.
- Feeds the display and motion logic: SPEED drives the level readout; TICK advances whatever moves at the selected speed.

---
 rtl/speed_level_ticker_pkg.sv | 25 ++
 rtl/speed_divider.sv | 55 +++++
 rtl/speed_level_ticker.sv | 69 ++++++
 tb/tb_speed_level_ticker.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/speed_level_ticker_pkg.sv
// Shared constants and helpers for the speed-level path: default sizing, the
// reduced simulation sizing, and the step decode type.
package speed_level_ticker_pkg;

    localparam int unsigned DEFAULT_MAX_LEVEL = 7;
    localparam int unsigned DEFAULT_BASE_DIV  = 50000;

    // Reduced sizing shared by all speed-path benches.
    localparam int unsigned SIM_MAX_LEVEL = 3;
    localparam int unsigned SIM_BASE_DIV  = 4;

    typedef enum logic [1:0] {
        StepHold,
        StepUp,
        StepDown
    } step_e;

    // Tick period in clock cycles for a non-zero level.
    function automatic int unsigned period_cycles(input int unsigned max_level,
                                                  input int unsigned base_div,
                                                  input int unsigned level);
        return (max_level + 1 - level) * base_div;
    endfunction

endpackage

// File: rtl/speed_divider.sv
// Level-dependent divider: emits a one-cycle TICK every PERIOD(level) cycles,
// restarting whenever the level changes and idling at level 0.
module speed_divider
    import speed_level_ticker_pkg::*;
#(
    parameter int unsigned MAX_LEVEL = DEFAULT_MAX_LEVEL,
    parameter int unsigned BASE_DIV  = DEFAULT_BASE_DIV,
    parameter int unsigned LEVEL_W   = $clog2(MAX_LEVEL + 1)
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic [LEVEL_W-1:0] level,
    input  logic               restart,
    output logic               TICK
);

    localparam int unsigned CNT_W_RAW = $clog2(MAX_LEVEL * BASE_DIV);
    // Keep at least one bit when MAX_LEVEL*BASE_DIV == 1.
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam int unsigned PER_W     = CNT_W + 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic [PER_W-1:0] period;
    logic [PER_W-1:0] last;

    always_comb begin
        period = PER_W'(period_cycles(MAX_LEVEL, BASE_DIV, 32'(level)));
        last   = period - PER_W'(1);
    end

    always_comb begin
        count_d = count_q + CNT_W'(1);
        tick_d  = 1'b0;
        if (restart || (level == '0)) begin
            count_d = '0;
        end else if ({1'b0, count_q} == last) begin
            count_d = '0;
            tick_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign TICK = tick_q;

endmodule

// File: rtl/speed_level_ticker.sv
// Saturating speed level driven by ENABLE/UP_DOWN step commands, with a
// speed-dependent TICK strobe and level boundary flags.
module speed_level_ticker
    import speed_level_ticker_pkg::*;
#(
    parameter int unsigned MAX_LEVEL = DEFAULT_MAX_LEVEL,
    parameter int unsigned BASE_DIV  = DEFAULT_BASE_DIV,
    localparam int unsigned LEVEL_W  = $clog2(MAX_LEVEL + 1)
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               ENABLE,
    input  logic               UP_DOWN,
    output logic [LEVEL_W-1:0] SPEED,
    output logic               TICK,
    output logic               AT_MAX,
    output logic               AT_MIN
);

    step_e              step;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               restart;

    // Saturated requests decode to StepHold so they never restart the divider.
    always_comb begin
        step = StepHold;
        if (ENABLE && UP_DOWN && (level_q != LEVEL_W'(MAX_LEVEL))) begin
            step = StepUp;
        end else if (ENABLE && !UP_DOWN && (level_q != '0)) begin
            step = StepDown;
        end
    end

    always_comb begin
        level_d = level_q;
        unique case (step)
            StepUp:   level_d = level_q + LEVEL_W'(1);
            StepDown: level_d = level_q - LEVEL_W'(1);
            default:  level_d = level_q;
        endcase
    end

    assign restart = (step != StepHold);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign SPEED  = level_q;
    assign AT_MAX = (level_q == LEVEL_W'(MAX_LEVEL));
    assign AT_MIN = (level_q == '0);

    speed_divider #(
        .MAX_LEVEL (MAX_LEVEL),
        .BASE_DIV  (BASE_DIV),
        .LEVEL_W   (LEVEL_W)
    ) u_divider (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .level   (level_q),
        .restart (restart),
        .TICK    (TICK)
    );

endmodule

// File: tb/tb_speed_level_ticker.sv
// Bench for speed_level_ticker at the reduced simulation sizing: vector table,
// directed tick-timing sequences and a randomized run against a reference model.
module tb_speed_level_ticker;
    import speed_level_ticker_pkg::*;

    localparam int unsigned ML = SIM_MAX_LEVEL;
    localparam int unsigned BD = SIM_BASE_DIV;
    localparam int unsigned LW = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b0;
    logic          ud = 1'b0;
    logic [LW-1:0] speed;
    logic          tick;
    logic          at_max;
    logic          at_min;

    int total = 0;
    int bad   = 0;

    // Reference model: level plus edges elapsed since the divider last restarted.
    int m_lvl   = 0;
    int m_since = 0;
    bit m_tick  = 1'b0;

    typedef struct {
        bit rstn;
        bit en;
        bit ud;
        int speed;
        bit tick;
    } vec_t;

    vec_t vecs[$];

    speed_level_ticker #(
        .MAX_LEVEL (ML),
        .BASE_DIV  (BD)
    ) dut (
        .CLK     (clk),
        .RSTn    (rstn),
        .ENABLE  (en),
        .UP_DOWN (ud),
        .SPEED   (speed),
        .TICK    (tick),
        .AT_MAX  (at_max),
        .AT_MIN  (at_min)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit u);
        int nl;
        int p;
        if (!r) begin
            m_lvl = 0; m_since = 0; m_tick = 1'b0;
        end else begin
            nl = m_lvl;
            if (e && u && m_lvl < int'(ML)) nl = m_lvl + 1;
            else if (e && !u && m_lvl > 0) nl = m_lvl - 1;
            if (nl != m_lvl) begin
                m_lvl = nl; m_since = 0; m_tick = 1'b0;
            end else if (m_lvl == 0) begin
                m_since = 0; m_tick = 1'b0;
            end else begin
                p = (int'(ML) + 1 - m_lvl) * int'(BD);
                m_since++;
                m_tick = (m_since % p) == 0;
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
    task automatic step(input bit r, input bit e, input bit u);
        rstn = r; en = e; ud = u;
        @(posedge clk);
        model_edge(r, e, u);
        #1;
        check("speed", int'(speed), m_lvl);
        check("tick", int'(tick), int'(m_tick));
        check("at_max", int'(at_max), int'(m_lvl == int'(ML)));
        check("at_min", int'(at_min), int'(m_lvl == 0));
    endtask

    // Idle cycles until TICK is seen; -1 if the bound expires.
    task automatic idle_until_tick(input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (tick) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int gap;

        // Reset with a pending up request, then the up/down saturation walk.
        vecs.push_back('{1'b0, 1'b1, 1'b1, 0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 3, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 3, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 0, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rstn, vecs[i].en, vecs[i].ud);
            check($sformatf("vec%0d speed", i), int'(speed), vecs[i].speed);
            check($sformatf("vec%0d tick", i), int'(tick), int'(vecs[i].tick));
        end

        // Stopped: no ticks over 20 idle cycles.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);

        // Level 1: first tick 12 cycles after the step edge, then every 12.
        step(1'b1, 1'b1, 1'b1);
        idle_until_tick(40, gap);
        check("lvl1 first gap", gap, 12);
        idle_until_tick(40, gap);
        check("lvl1 period", gap, 12);

        // Climb to saturation; the saturated step must not restart the divider.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("at_max after climb", int'(at_max), 1);
        idle_until_tick(20, gap);
        check("sat step no restart", gap, 3);
        idle_until_tick(20, gap);
        check("lvl3 period", gap, 4);

        // Level 2, step up at count 5: next tick 4 cycles after the step edge.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        idle_until_tick(20, gap);
        check("mid-count restart gap", gap, 4);

        // Synchronous reset mid-count, then a fresh 12-cycle period.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("reset speed", int'(speed), 0);
        check("reset tick", int'(tick), 0);
        step(1'b1, 1'b1, 1'b1);
        idle_until_tick(40, gap);
        check("post-reset gap", gap, 12);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
